// File: rtl/seq_alu.sv
// Sequential handshaked ALU: single-cycle logic/arith ops plus iterative shift-add MUL and restoring DIV.
// Optional divider built only when SEQ_ALU_DIV_EN is defined; otherwise opcode 1010 is illegal.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [3:0]       i_opcode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carryin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out,
    output logic [WIDTH-1:0] o_extra,
    output logic             o_flag_zero,
    output logic             o_flag_carry,
    output logic             o_flag_err
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_XNOR = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_ADD  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1010;
    localparam logic [3:0] OP_SHL  = 4'b1011;

    typedef enum logic [1:0] {IDLE, MULT, DIVD} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   r_extra;
    logic               r_zero;
    logic               r_carry;
    logic               r_err;

    logic               w_accept;
    logic               w_out_fire;
    logic               w_multi;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_shl;
    logic [WIDTH-1:0]   w_sc_out;
    logic [WIDTH-1:0]   w_sc_extra;
    logic               w_sc_carry;
    logic               w_sc_err;
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_mul_next;
    logic               w_wr;
    logic [WIDTH-1:0]   w_wr_out;
    logic [WIDTH-1:0]   w_wr_extra;
    logic               w_wr_carry;
    logic               w_wr_err;

    assign o_in_ready  = (r_state == IDLE) && (!r_out_valid || i_out_ready);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_out_fire  = r_out_valid && i_out_ready;
    assign o_out_valid = r_out_valid;
    assign o_out       = r_out;
    assign o_extra     = r_extra;
    assign o_flag_zero  = r_zero;
    assign o_flag_carry = r_carry;
    assign o_flag_err   = r_err;

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0]     w_dshift;
    logic [WIDTH:0]     w_ddiff;
    logic [2*WIDTH-1:0] w_div_next;

    // Bit WIDTH of the difference is set exactly when the trial subtraction underflows.
    assign w_dshift   = r_p[2*WIDTH-1:WIDTH-1];
    assign w_ddiff    = w_dshift - {1'b0, r_opnd};
    assign w_div_next = {(w_ddiff[WIDTH] ? w_dshift[WIDTH-1:0] : w_ddiff[WIDTH-1:0]),
                         r_p[WIDTH-2:0], ~w_ddiff[WIDTH]};
    assign w_multi    = (i_opcode == OP_MUL) || ((i_opcode == OP_DIV) && (i_b != '0));
`else
    assign w_multi    = (i_opcode == OP_MUL);
`endif

    assign w_madd     = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_madd, r_p[WIDTH-1:1]};

    always_comb begin
        w_sc_out   = '0;
        w_sc_extra = '0;
        w_sc_carry = 1'b0;
        w_sc_err   = 1'b0;
        w_sum      = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_carryin};
        w_shl      = {{WIDTH{1'b0}}, i_a} << i_b;
        case (i_opcode)
            OP_AND:  w_sc_out = i_a & i_b;
            OP_OR:   w_sc_out = i_a | i_b;
            OP_NAND: w_sc_out = ~(i_a & i_b);
            OP_NOR:  w_sc_out = ~(i_a | i_b);
            OP_XOR:  w_sc_out = i_a ^ i_b;
            OP_XNOR: w_sc_out = ~(i_a ^ i_b);
            OP_NOT:  w_sc_out = ~i_a;
            OP_ADD: begin
                w_sc_out   = w_sum[WIDTH-1:0];
                w_sc_carry = w_sum[WIDTH];
                w_sc_extra = {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
            end
            OP_SUB: begin
                w_sum      = {1'b0, i_a} - {1'b0, i_b} - {{WIDTH{1'b0}}, i_carryin};
                w_sc_out   = w_sum[WIDTH-1:0];
                w_sc_carry = w_sum[WIDTH];
                w_sc_extra = {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
            end
            OP_MUL: ;
`ifdef SEQ_ALU_DIV_EN
            OP_DIV: begin
                w_sc_out   = '1;
                w_sc_extra = i_a;
                w_sc_err   = 1'b1;
            end
`endif
            OP_SHL: begin
                w_sc_out   = w_shl[WIDTH-1:0];
                w_sc_extra = w_shl[2*WIDTH-1:WIDTH];
            end
            default: w_sc_err = 1'b1;
        endcase
    end

    // Selects which result, if any, lands in the output registers this cycle.
    always_comb begin
        w_wr       = 1'b0;
        w_wr_out   = '0;
        w_wr_extra = '0;
        w_wr_carry = 1'b0;
        w_wr_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_multi) begin
                    w_wr       = 1'b1;
                    w_wr_out   = w_sc_out;
                    w_wr_extra = w_sc_extra;
                    w_wr_carry = w_sc_carry;
                    w_wr_err   = w_sc_err;
                end
            end
            MULT: begin
                w_wr       = (r_cnt == '0);
                w_wr_out   = w_mul_next[2*WIDTH-1:WIDTH];
                w_wr_extra = w_mul_next[WIDTH-1:0];
            end
`ifdef SEQ_ALU_DIV_EN
            DIVD: begin
                w_wr       = (r_cnt == '0);
                w_wr_out   = w_div_next[WIDTH-1:0];
                w_wr_extra = w_div_next[2*WIDTH-1:WIDTH];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_p         <= '0;
            r_opnd      <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_extra     <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_wr) begin
                r_out       <= w_wr_out;
                r_extra     <= w_wr_extra;
                r_zero      <= (w_wr_out == '0);
                r_carry     <= w_wr_carry;
                r_err       <= w_wr_err;
                r_out_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept && w_multi) begin
                        r_cnt <= CW'(WIDTH - 1);
                        if (i_opcode == OP_MUL) begin
                            r_p     <= {{WIDTH{1'b0}}, i_b};
                            r_opnd  <= i_a;
                            r_state <= MULT;
                        end
`ifdef SEQ_ALU_DIV_EN
                        else begin
                            r_p     <= {{WIDTH{1'b0}}, i_a};
                            r_opnd  <= i_b;
                            r_state <= DIVD;
                        end
`endif
                    end
                end
                MULT: begin
                    r_p <= w_mul_next;
                    if (r_cnt == '0) r_state <= IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
`ifdef SEQ_ALU_DIV_EN
                DIVD: begin
                    r_p <= w_div_next;
                    if (r_cnt == '0) r_state <= IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu against an arithmetic reference model.
// Honours SEQ_ALU_DIV_EN the same way the design does.
module tb_seq_alu;

    localparam int W = 8;

    logic         clk;
    logic         rstN;
    logic         inValid;
    logic         inReady;
    logic [3:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carryIn;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] outRes;
    logic [W-1:0] extraRes;
    logic         flagZero;
    logic         flagCarry;
    logic         flagErr;

    int checkCount = 0;
    int errorCount = 0;

    seq_alu #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_in_valid   (inValid),
        .o_in_ready   (inReady),
        .i_opcode     (opcode),
        .i_a          (a),
        .i_b          (b),
        .i_carryin    (carryIn),
        .o_out_valid  (outValid),
        .i_out_ready  (outReady),
        .o_out        (outRes),
        .o_extra      (extraRes),
        .o_flag_zero  (flagZero),
        .o_flag_carry (flagCarry),
        .o_flag_err   (flagErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference results straight from the opcode table, using wide integer arithmetic.
    function automatic void modelOp(input logic [3:0] op, input logic [W-1:0] opA, input logic [W-1:0] opB,
                                    input logic cin, output logic [W-1:0] eOut, output logic [W-1:0] eExtra,
                                    output logic eCarry, output logic eErr, output int eLat);
        longint unsigned la = 64'(opA);
        longint unsigned lb = 64'(opB);
        longint unsigned p;
        eOut = '0; eExtra = '0; eCarry = 1'b0; eErr = 1'b0; eLat = 0;
        case (op)
            4'd0: eOut = opA & opB;
            4'd1: eOut = opA | opB;
            4'd2: eOut = ~(opA & opB);
            4'd3: eOut = ~(opA | opB);
            4'd4: eOut = opA ^ opB;
            4'd5: eOut = ~(opA ^ opB);
            4'd6: eOut = ~opA;
            4'd7: begin
                p = la + lb + 64'(cin);
                eOut = W'(p);
                eCarry = (p >= (64'd1 << W));
                eExtra = {{(W-1){1'b0}}, eCarry};
            end
            4'd8: begin
                eCarry = (la < lb + 64'(cin));
                eOut = W'(la - lb - 64'(cin));
                eExtra = {{(W-1){1'b0}}, eCarry};
            end
            4'd9: begin
                p = la * lb;
                eOut = W'(p >> W);
                eExtra = W'(p);
                eLat = W;
            end
            4'd10: begin
`ifdef SEQ_ALU_DIV_EN
                if (lb == 0) begin
                    eOut = '1; eExtra = opA; eErr = 1'b1;
                end else begin
                    eOut = W'(la / lb); eExtra = W'(la % lb); eLat = W;
                end
`else
                eErr = 1'b1;
`endif
            end
            4'd11: begin
                if (lb < 2 * W) begin
                    p = la << lb;
                    eOut = W'(p);
                    eExtra = W'(p >> W);
                end
            end
            default: eErr = 1'b1;
        endcase
    endfunction

    // Presents one op, waits for its result, checks it, optionally stalls the consumer.
    // Entered and left on a falling edge so back-to-back calls overlap accept and emit.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] opA, input logic [W-1:0] opB,
                                 input logic cin, input int hold);
        logic [W-1:0] eOut, eExtra;
        logic eCarry, eErr;
        int eLat, n, lat;
        bit sawReady;
        modelOp(op, opA, opB, cin, eOut, eExtra, eCarry, eErr, eLat);
        opcode = op; a = opA; b = opB; carryIn = cin; inValid = 1'b1; outReady = 1'b1;
        n = 0;
        while (!inReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!inReady) begin
            checkOutput("acceptTimeout", 64'(inReady), 64'd1);
            inValid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
        opcode = 4'($urandom); a = W'($urandom); b = W'($urandom); carryIn = 1'($urandom);
        @(negedge clk);
        lat = 0;
        sawReady = 1'b0;
        while (!outValid && lat < 200) begin
            if (inReady) sawReady = 1'b1;
            @(negedge clk);
            lat++;
        end
        checkOutput($sformatf("latency op%0d", op), 64'(lat), 64'(eLat));
        if (eLat > 0) checkOutput("busyInReady", 64'(sawReady), 64'd0);
        checkOutput($sformatf("out op%0d", op), 64'(outRes), 64'(eOut));
        checkOutput($sformatf("extra op%0d", op), 64'(extraRes), 64'(eExtra));
        checkOutput($sformatf("zero op%0d", op), 64'(flagZero), 64'(eOut == '0));
        checkOutput($sformatf("carry op%0d", op), 64'(flagCarry), 64'(eCarry));
        checkOutput($sformatf("err op%0d", op), 64'(flagErr), 64'(eErr));
        if (hold > 0) begin
            outReady = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                checkOutput("holdValid", 64'(outValid), 64'd1);
                checkOutput("holdOut", 64'(outRes), 64'(eOut));
                checkOutput("holdInReady", 64'(inReady), 64'd0);
            end
            outReady = 1'b1;
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " outValid"}, 64'(outValid), 64'd0);
        checkOutput({tag, " inReady"}, 64'(inReady), 64'd1);
        checkOutput({tag, " out"}, 64'(outRes), 64'd0);
        checkOutput({tag, " extra"}, 64'(extraRes), 64'd0);
        checkOutput({tag, " flags"}, 64'({flagZero, flagCarry, flagErr}), 64'd0);
    endtask

    task automatic drain();
        inValid = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] rop;
        logic [W-1:0] ra, rb;
        rstN = 1'b0; inValid = 1'b0; opcode = '0; a = '0; b = '0; carryIn = 1'b0; outReady = 1'b1;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rstN = 1'b1;
        @(negedge clk);

        applyStimulus(4'd7, 8'hFF, 8'h01, 1'b0, 0);
        applyStimulus(4'd8, 8'h05, 8'h05, 1'b1, 0);
        applyStimulus(4'd9, 8'hFF, 8'hFF, 1'b0, 0);
        applyStimulus(4'd10, 8'd200, 8'd7, 1'b0, 0);
        applyStimulus(4'd10, 8'd5, 8'd0, 1'b0, 0);
        applyStimulus(4'd11, 8'h81, 8'd1, 1'b0, 0);
        applyStimulus(4'd11, 8'h81, 8'd16, 1'b0, 0);
        applyStimulus(4'd14, 8'h12, 8'h34, 1'b0, 0);

        // Backpressure: XOR result must stay put while the queued OR waits behind it.
        drain();
        outReady = 1'b0;
        opcode = 4'd4; a = 8'h0F; b = 8'hF0; carryIn = 1'b0; inValid = 1'b1;
        checkOutput("bpInReadyIdle", 64'(inReady), 64'd1);
        @(posedge clk);
        #1;
        opcode = 4'd1; a = 8'h0F; b = 8'h30;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bpValid", 64'(outValid), 64'd1);
            checkOutput("bpOut", 64'(outRes), 64'hFF);
            checkOutput("bpInReady", 64'(inReady), 64'd0);
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        @(negedge clk);
        checkOutput("bpOrValid", 64'(outValid), 64'd1);
        checkOutput("bpOrOut", 64'(outRes), 64'h3F);
        @(negedge clk);
        checkOutput("bpNoDup", 64'(outValid), 64'd0);

        // Reset in the middle of a multiply discards it entirely.
        drain();
        opcode = 4'd9; a = 8'hFF; b = 8'hFF; carryIn = 1'b0; inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b0;
        #1;
        checkResetState("midMulReset");
        @(negedge clk);
        rstN = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("midMulNoResult", 64'(outValid), 64'd0);
        applyStimulus(4'd7, 8'd1, 8'd1, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = W'($urandom);
            rb = W'($urandom);
            if (rop == 4'd11) rb = W'($urandom_range(0, 2 * W + 1));
            if (rop == 4'd10 && $urandom_range(0, 3) == 0) rb = '0;
            applyStimulus(rop, ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
        end

        drain();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
